morse_sequencer: RTL and testbench

- Converts a latched 10-bit Morse word into timed tone-enable pulses `short` / `long`, one symbol at a time.
- Sits between the 10-bit morse holding register and the sound module, which turns `short` / `long` into audio.
- Owns all Morse timing: dot/dash duration, inter-symbol gap, letter space.
- Provides start/busy/done handshake so the microcontroller can sequence words.

---
 rtl/morse_sequencer_if.sv | 21 ++
 rtl/morse_sequencer.sv | 157 +++++++++++++++
 tb/tb_morse_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/morse_sequencer_if.sv
// Handshake and tone bundle between the controller, the Morse sequencer
// and the sound module.
interface morse_sequencer_if;
    logic       start;
    logic [9:0] morse;
    logic       short_tone;
    logic       long_tone;
    logic       busy;
    logic       done;
    logic [2:0] sym_idx;

    modport master (
        output start, morse,
        input  short_tone, long_tone, busy, done, sym_idx
    );

    modport slave (
        input  start, morse,
        output short_tone, long_tone, busy, done, sym_idx
    );
endinterface

// File: rtl/morse_sequencer.sv
// Plays a latched 5-symbol Morse word as timed dot/dash tone enables,
// with start/busy/done sequencing towards the controller.
module morse_sequencer #(
    parameter int UNIT_CYCLES = 6000000,
    parameter int CNT_W       = 25
) (
    input  logic              clk,
    input  logic              reset,
    morse_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_TONE,
        S_GAP,
        S_SPACE,
        S_FINISH
    } state_t;

    localparam logic [CNT_W-1:0] UNIT_LOAD = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [2:0]       LAST_SYM  = 3'd4;

    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic [9:0]       shift, shift_n;
    logic [2:0]       idx, idx_n;
    logic             short_q, short_n;
    logic             long_q, long_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            shift   <= '0;
            idx     <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            shift   <= shift_n;
            idx     <= idx_n;
            short_q <= short_n;
            long_q  <= long_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // Outputs are computed one step ahead so every port comes straight from a flop.
    always_comb begin
        state_n = state;
        timer_n = timer;
        shift_n = shift;
        idx_n   = idx;
        short_n = short_q;
        long_n  = long_q;
        busy_n  = busy_q;
        done_n  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    shift_n = bus.morse;
                    idx_n   = '0;
                    busy_n  = 1'b1;
                    state_n = S_DECODE;
                end
            end

            S_DECODE: begin
                unique case (shift[9:8])
                    2'b00: begin
                        state_n = S_FINISH;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        idx_n   = '0;
                    end
                    2'b01: begin
                        state_n = S_TONE;
                        short_n = 1'b1;
                        timer_n = UNIT_LOAD;
                    end
                    2'b10: begin
                        state_n = S_TONE;
                        long_n  = 1'b1;
                        timer_n = DASH_LOAD;
                    end
                    default: begin
                        state_n = S_SPACE;
                        timer_n = DASH_LOAD;
                    end
                endcase
            end

            S_TONE: begin
                if (timer == '0) begin
                    short_n = 1'b0;
                    long_n  = 1'b0;
                    if (idx == LAST_SYM) begin
                        state_n = S_FINISH;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        idx_n   = '0;
                    end else begin
                        state_n = S_GAP;
                        timer_n = UNIT_LOAD;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end

            S_GAP, S_SPACE: begin
                if (timer == '0) begin
                    if (idx == LAST_SYM) begin
                        state_n = S_FINISH;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        idx_n   = '0;
                    end else begin
                        state_n = S_DECODE;
                        shift_n = {shift[7:0], 2'b00};
                        idx_n   = idx + 1'b1;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end

            S_FINISH: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
                short_n = 1'b0;
                long_n  = 1'b0;
                busy_n  = 1'b0;
                idx_n   = '0;
            end
        endcase
    end

    assign bus.short_tone = short_q;
    assign bus.long_tone  = long_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sym_idx    = idx;

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed vector bench for morse_sequencer with a 4-cycle Morse unit.
module tb_morse_sequencer;

    localparam int U = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    morse_sequencer_if bus();

    morse_sequencer #(.UNIT_CYCLES(U), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // exp = {short, long, busy, done, sym_idx[2:0]}, sampled after each edge
    typedef struct {
        logic       rst;
        logic       start;
        logic [9:0] morse;
        int         reps;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [9:0] W_A = 10'b01_10_00_00_00;
    localparam logic [9:0] W_B = 10'b11_01_01_01_01;
    localparam logic [9:0] W_C = 10'b10_00_00_00_00;
    localparam logic [9:0] W_D = 10'b01_00_00_00_00;
    localparam logic [9:0] JUNK = 10'b11_11_11_11_11;

    task automatic add(input logic rst, input logic st, input logic [9:0] m, input int n,
                       input logic s, input logic l, input logic b, input logic d,
                       input logic [2:0] i);
        vec_t v;
        v.rst = rst; v.start = st; v.morse = m; v.reps = n; v.exp = {s, l, b, d, i};
        vecs.push_back(v);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic add_word_a();
        add(1, 1, W_A,  1,  0, 0, 1, 0, 0);  // DECODE
        add(1, 0, JUNK, 4,  1, 0, 1, 0, 0);  // dot
        add(1, 0, JUNK, 4,  0, 0, 1, 0, 0);  // gap
        add(1, 0, JUNK, 1,  0, 0, 1, 0, 1);  // DECODE
        add(1, 0, JUNK, 12, 0, 1, 1, 0, 1);  // dash
        add(1, 0, JUNK, 4,  0, 0, 1, 0, 1);  // gap
        add(1, 0, JUNK, 1,  0, 0, 1, 0, 2);  // DECODE of 00
        add(1, 0, JUNK, 1,  0, 0, 0, 1, 0);  // FINISH
        add(1, 0, JUNK, 3,  0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [6:0] act;
        int t, w, k;

        bus.start = 1'b0;
        bus.morse = '0;

        // reset and idle
        add(0, 0, 0, 3,  0, 0, 0, 0, 0);
        add(1, 0, 0, 10, 0, 0, 0, 0, 0);

        // dot, dash, end; morse input scribbled while busy
        add_word_a();

        // letter space then four dots, last dot goes straight to FINISH
        add(1, 1, W_B, 1,  0, 0, 1, 0, 0);
        add(1, 0, 0,   12, 0, 0, 1, 0, 0);
        for (int s = 1; s <= 4; s++) begin
            add(1, 0, 0, 1, 0, 0, 1, 0, 3'(s));
            add(1, 0, 0, 4, 1, 0, 1, 0, 3'(s));
            if (s < 4) add(1, 0, 0, 4, 0, 0, 1, 0, 3'(s));
        end
        add(1, 0, 0, 1, 0, 0, 0, 1, 0);
        add(1, 0, 0, 2, 0, 0, 0, 0, 0);

        // empty word; start during FINISH is ignored
        add(1, 1, 10'h000, 1, 0, 0, 1, 0, 0);
        add(1, 0, 0,       1, 0, 0, 0, 1, 0);
        add(1, 1, W_A,     1, 0, 0, 0, 0, 0);
        add(1, 0, 0,       2, 0, 0, 0, 0, 0);

        // second start mid-dash is ignored
        add(1, 1, W_C, 1, 0, 0, 1, 0, 0);
        add(1, 0, 0,   5, 0, 1, 1, 0, 0);
        add(1, 1, W_B, 1, 0, 1, 1, 0, 0);
        add(1, 0, 0,   6, 0, 1, 1, 0, 0);
        add(1, 0, 0,   4, 0, 0, 1, 0, 0);
        add(1, 0, 0,   1, 0, 0, 1, 0, 1);
        add(1, 0, 0,   1, 0, 0, 0, 1, 0);
        add(1, 0, 0,   3, 0, 0, 0, 0, 0);

        // reset mid-dash, then a fresh word from symbol 0
        add(1, 1, W_C, 1, 0, 0, 1, 0, 0);
        add(1, 0, 0,   3, 0, 1, 1, 0, 0);
        add(0, 0, 0,   1, 0, 0, 0, 0, 0);
        add(1, 0, 0,   2, 0, 0, 0, 0, 0);
        add_word_a();

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                @(negedge clk);
                reset     = vecs[i].rst;
                bus.start = (r == 0) ? vecs[i].start : 1'b0;
                bus.morse = vecs[i].morse;
                @(posedge clk);
                #1;
                act = {bus.short_tone, bus.long_tone, bus.busy, bus.done, bus.sym_idx};
                n_vec++;
                if (act !== vecs[i].exp) begin
                    n_err++;
                    $display("FAIL vec%0d rep%0d: got s,l,b,d,idx=%b required %b",
                             i, r, act, vecs[i].exp);
                end
            end
        end

        // single dot measured with bounded waits
        @(negedge clk);
        bus.start = 1'b1;
        bus.morse = W_D;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.start = 1'b0;
        t = 0;
        while (!bus.short_tone && t < 10) begin
            @(posedge clk); #1; t++;
        end
        check_int("dot_latency", t, 1);
        w = 0;
        while (bus.short_tone && w < 20) begin
            w++; @(posedge clk); #1;
        end
        check_int("dot_width", w, U);
        k = 1;
        while (!bus.done && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check_int("done_after_dot", k, U + 2);
        @(posedge clk); #1;
        check_int("busy_after_done", int'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
